regfile_pc_bank: RTL

//  Parametrised register bank for the pipelined core: DEPTH x WIDTH registers, one write port and
//  two read ports. Register PC_IDX is the program counter, with its own load port and auto-increment.
//  The bank sits between the decode stage (reads) and the writeback stage (writes).
//  It generalises the single 16-bit active-low-write register to N entries, bypass and PC control.

---
 rtl/regfile_pc_bank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_pc_bank.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pc_bank
//  Description : DEPTH x WIDTH register bank with one write port, two
//                combinational read ports and a program-counter entry at
//                PC_IDX that has its own load port and auto-increment.
//                Sits between decode (reads) and writeback (writes).
//
//  Ports
//    clk        in   1      clock, all state changes on posedge
//    reset      in   1      synchronous, active-low reset
//    wr_n       in   1      active-low general write enable
//    wr_addr    in   AW     general write address
//    wr_data    in   WIDTH  general write data
//    rd_addr_a  in   AW     read port A address
//    rd_data_a  out  WIDTH  read port A data (combinational)
//    rd_addr_b  in   AW     read port B address
//    rd_data_b  out  WIDTH  read port B data (combinational)
//    pc_wr_n    in   1      active-low PC load (branch/jump)
//    pc_in      in   WIDTH  PC load value
//    pc_inc     in   1      active-high PC increment
//    pc_out     out  WIDTH  registered PC, never bypassed
//
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_pc_bank #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 8,
    parameter int               AW       = 3,
    parameter int               PC_IDX   = 7,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_STEP  = 1,
    parameter bit               BYPASS   = 1'b1,
    parameter bit               ZERO_R0  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_n,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             pc_wr_n,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [AW-1:0] c_pc_addr = AW'(PC_IDX);

    // Current contents of every entry, one element per storage slot.
    logic [WIDTH-1:0] w_regs [DEPTH];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == PC_IDX) begin : g_pc
            logic [WIDTH-1:0] r_pc;

            // A branch load beats a writeback to the PC slot, which in
            // turn beats the fetch increment.
            always_ff @(posedge clk) begin
                if (!reset)
                    r_pc <= RESET_PC;
                else if (!pc_wr_n)
                    r_pc <= pc_in;
                else if (!wr_n && wr_addr == c_pc_addr)
                    r_pc <= wr_data;
                else if (pc_inc)
                    r_pc <= r_pc + PC_STEP;
            end

            assign w_regs[i] = r_pc;
        end else if (ZERO_R0 && i == 0) begin : g_zero
            // Hard-wired zero register: no storage at all.
            assign w_regs[i] = '0;
        end else begin : g_gen
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (!reset)
                    r_q <= '0;
                else if (!wr_n && wr_addr == AW'(i))
                    r_q <= wr_data;
            end

            assign w_regs[i] = r_q;
        end
    end

    // ------------------------------------------------------------------
    // Read ports (identical logic, instantiated per port)
    // ------------------------------------------------------------------
    logic [AW-1:0]    w_rd_addr [2];
    logic [WIDTH-1:0] w_rd_data [2];

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_byp;
        logic w_zero;

        assign w_zero = ZERO_R0 && (w_rd_addr[p] == '0);

        // Forward the writeback value unless a branch load is hitting the
        // PC on the same edge -- then the written value never lands, so
        // the registered PC is the honest answer.
        assign w_byp = BYPASS && !wr_n && (wr_addr == w_rd_addr[p])
                       && ((wr_addr != c_pc_addr) || pc_wr_n);

        always_comb begin
            w_rd_data[p] = w_regs[w_rd_addr[p]];
            if (w_byp)
                w_rd_data[p] = wr_data;
            if (w_zero)
                w_rd_data[p] = '0;
        end
    end

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
    assign pc_out    = w_regs[PC_IDX];

endmodule
`default_nettype wire
